freq_divider_bank: RTL and testbench

//  Synchronous, parametrised frequency divider bank for the panel design.
//  NUM_CH independent channels derive one-cycle clock-enable ticks from the single system clock.

---
 rtl/freq_div_pkg.sv | 19 +
 rtl/freq_div_chan.sv | 98 +++++++++
 rtl/freq_divider_bank.sv | 47 ++++
 tb/tb_freq_divider_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared definitions for the frequency divider bank: channel limits,
// default counter width, div_sel width and the zero-divisor mapping.
package freq_div_pkg;

    localparam int MAX_CH    = 8;
    localparam int CNT_W_DEF = 24;

    // Width of the channel-select bus; one bit minimum for a single channel.
    function automatic int sel_w(input int num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // Divisor 0 runs like divisor 1. Operates on a 64-bit container so it
    // serves any CNT_W up to 64; callers cast in and out.
    function automatic logic [63:0] eff_div(input logic [63:0] d);
        return (d == 64'd0) ? 64'd1 : d;
    endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One divider channel: counter, active divisor, shadow divisor, pending flag,
// registered tick and optional square wave (built when FREQ_DIV_SQ_OUT_EN).
// Ports: clk, rst_n, i_en, i_clr, i_wr, i_val -> o_pend, o_tick, o_sq.
module freq_div_chan
    import freq_div_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = {CNT_W{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_val,
    output logic             o_pend,
    output logic             o_tick,
    output logic             o_sq
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pend;
    logic             r_tick;

    logic [CNT_W-1:0] w_deff;
    logic             w_wrap;
    logic             w_load;
    logic [CNT_W-1:0] w_next_div;

    assign w_deff = CNT_W'(eff_div(64'(r_div)));
    // Wrap only advances while enabled; clr overrides it below.
    assign w_wrap = i_en && (r_cnt == (w_deff - CNT_W'(1)));
    // A same-cycle write wins over an older pending shadow.
    assign w_load     = i_wr || r_pend;
    assign w_next_div = i_wr ? i_val : r_shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_div    <= DIV_RST;
            r_shadow <= DIV_RST;
            r_pend   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            if (i_wr) begin
                r_shadow <= i_val;
            end
            if (i_clr) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_pend <= 1'b0;
                if (w_load) begin
                    r_div <= w_next_div;
                end
            end else if (w_wrap) begin
                // Divisor changes only here or on clr, so cnt < D always.
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_pend <= 1'b0;
                if (w_load) begin
                    r_div <= w_next_div;
                end
            end else begin
                if (i_en) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                r_tick <= 1'b0;
                if (i_wr) begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

`ifdef FREQ_DIV_SQ_OUT_EN
    logic r_sq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sq <= 1'b0;
        end else if (i_clr) begin
            r_sq <= 1'b0;
        end else if (w_wrap) begin
            r_sq <= ~r_sq;
        end
    end

    assign o_sq = r_sq;
`else
    assign o_sq = 1'b0;
`endif

    assign o_pend = r_pend;
    assign o_tick = r_tick;

endmodule

// File: rtl/freq_divider_bank.sv
// NUM_CH-channel clock-enable divider bank; decodes div_wr/div_sel into
// per-channel write strobes. Ports: clk, rst_n, en, clr, div_wr, div_sel,
// div_val -> div_pend, tick, sq. Macro FREQ_DIV_SQ_OUT_EN builds sq flops.
module freq_divider_bank
    import freq_div_pkg::*;
#(
    parameter int               NUM_CH  = 2,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = {CNT_W{1'b1}}
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      div_wr,
    input  logic [sel_w(NUM_CH)-1:0]  div_sel,
    input  logic [CNT_W-1:0]          div_val,
    output logic [NUM_CH-1:0]         div_pend,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         sq
);

    localparam int SEL_W = sel_w(NUM_CH);

    logic [NUM_CH-1:0] w_wr;

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        // Selects >= NUM_CH match no channel, so such writes vanish.
        assign w_wr[n] = div_wr && (div_sel == SEL_W'(n));

        freq_div_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_RST)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (en),
            .i_clr  (clr),
            .i_wr   (w_wr[n]),
            .i_val  (div_val),
            .o_pend (div_pend[n]),
            .o_tick (tick[n]),
            .o_sq   (sq[n])
        );
    end

endmodule

// File: tb/tb_freq_divider_bank.sv
// Scoreboard bench for freq_divider_bank: driver predicts outputs from a
// period-position model and queues them; a monitor pops and compares.
module tb_freq_divider_bank;

    localparam int NCH   = 3;
    localparam int CW    = 8;
    localparam int SW    = 2;
    localparam int DRST  = 255;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] sq;
        logic [NCH-1:0] pend;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          div_wr = 1'b0;
    logic [SW-1:0] div_sel = '0;
    logic [CW-1:0] div_val = '0;
    logic [NCH-1:0] div_pend;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    int checks = 0;
    int errors = 0;
    exp_t q[$];

    // Reference: per channel, the active period, the stored next period,
    // how many enabled cycles of the current period have elapsed.
    int m_per[NCH];
    int m_next[NCH];
    int m_pos[NCH];
    bit m_pend[NCH];
    bit m_tick[NCH];
    bit m_sq[NCH];

    always #5 clk = ~clk;

    freq_divider_bank #(
        .NUM_CH  (NCH),
        .CNT_W   (CW),
        .DIV_RST (8'hFF)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_val  (div_val),
        .div_pend (div_pend),
        .tick     (tick),
        .sq       (sq)
    );

    function automatic exp_t snap();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            e.tick[c] = m_tick[c];
`ifdef FREQ_DIV_SQ_OUT_EN
            e.sq[c]   = m_sq[c];
`else
            e.sq[c]   = 1'b0;
`endif
            e.pend[c] = m_pend[c];
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_per[c]  = DRST;
            m_next[c] = DRST;
            m_pos[c]  = 0;
            m_pend[c] = 0;
            m_tick[c] = 0;
            m_sq[c]   = 0;
        end
    endtask

    task automatic model_step(bit e, bit c_, bit w, int s, int v);
        for (int c = 0; c < NCH; c++) begin
            bit hit = w && (s == c);
            int d   = (m_per[c] == 0) ? 1 : m_per[c];
            if (c_) begin
                m_pos[c]  = 0;
                m_tick[c] = 0;
                m_sq[c]   = 0;
                if (hit) m_per[c] = v;
                else if (m_pend[c]) m_per[c] = m_next[c];
                m_pend[c] = 0;
            end else if (e && (m_pos[c] + 1 == d)) begin
                m_pos[c]  = 0;
                m_tick[c] = 1;
                m_sq[c]   = !m_sq[c];
                if (hit) m_per[c] = v;
                else if (m_pend[c]) m_per[c] = m_next[c];
                m_pend[c] = 0;
            end else begin
                if (e) m_pos[c]++;
                m_tick[c] = 0;
                if (hit) m_pend[c] = 1;
            end
            if (hit) m_next[c] = v;
        end
    endtask

    task automatic cyc(bit e, bit c_, bit w, int s, int v);
        @(negedge clk);
        en = e;
        clr = c_;
        div_wr = w;
        div_sel = SW'(s);
        div_val = CW'(v);
        if (rst_n) model_step(e, c_, w, s, v);
        q.push_back(snap());
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic async_reset(int hold);
        exp_t z;
        @(negedge clk);
        en = 1'b1;
        clr = 1'b0;
        div_wr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        z = '0;
        checks++;
        if ({tick, sq, div_pend} != z) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h",
                     {tick, sq, div_pend}, z);
        end
        model_reset();
        q.push_back(snap());
        for (int i = 0; i < hold; i++) cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(0, 0, 0, 0, 0);
        q.push_back(snap());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (tick !== e.tick || sq !== e.sq || div_pend !== e.pend) begin
                    errors++;
                    $display("FAIL cycle t=%0t tick=%b/%b sq=%b/%b pend=%b/%b",
                             $time, tick, e.tick, sq, e.sq, div_pend, e.pend);
                end
            end
        end
    end

    initial begin : driver
        model_reset();
        repeat (2) cyc(0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(snap());
        // D=4 on ch0, D=1 on ch1, applied via clr for immediacy.
        cyc(0, 1, 1, 0, 4);
        cyc(0, 1, 1, 1, 1);
        run(20);
        // D=10 on ch0, then lower to 3 when cnt is 5.
        cyc(0, 1, 1, 0, 10);
        run(5);
        cyc(1, 0, 1, 0, 3);
        run(12);
        // Hold for 7 cycles mid-count.
        run(2);
        repeat (7) cyc(0, 0, 0, 0, 0);
        run(10);
        // Clear with a pending D=5.
        cyc(0, 0, 1, 0, 5);
        cyc(0, 1, 0, 0, 0);
        run(8);
        // D=0 on ch2; out-of-range select.
        cyc(0, 1, 1, 2, 0);
        cyc(1, 0, 1, 3, 7);
        run(6);
        // Async reset mid-count, then square wave with D=3.
        run(3);
        async_reset(2);
        cyc(0, 1, 1, 0, 3);
        run(14);
        // Randomized traffic with small divisors.
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(9, 0) != 0,
                $urandom_range(60, 0) == 0,
                $urandom_range(9, 0) == 0,
                int'($urandom_range(3, 0)),
                int'($urandom_range(12, 0)));
        end
        cyc(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
